div_share_ctrl: RTL and testbench

Arbiter and sequencer for the shared programmable clock divider (16-bit parallel-load divisor, pl/en/din inputs). Up to NREQ requesters each ask for the divider with their own divisor. Grants use round-robin order. The block drives the divider's pl/din/en pins: a one-cycle load, then run for the whole tenure, then a one-cycle drain before the next owner.

---
 rtl/div_share_pkg.sv | 15 +
 rtl/div_share_ctrl_rr_pick.sv | 33 +++
 rtl/div_share_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_div_share_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_pkg.sv
// div_share_pkg: shared types and defaults for the clock-divider share controller.
package div_share_pkg;

  // Controller sequence: arbitrate, load divisor, run, drain.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int DEF_DW      = 16;
  localparam int DEF_MIN_DIV = 2;

endpackage

// File: rtl/div_share_ctrl_rr_pick.sv
// rr_pick: combinational round-robin selector. Picks the first set request
// bit at or after ptr, wrapping around. ptr must be below NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  logic [PW-1:0] pos;

  // Scan farthest-to-nearest so the nearest candidate after ptr wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = PW'((int'(ptr) + k) % NREQ);
      if (req[pos]) begin
        valid     = 1'b1;
        idx       = pos;
        pick      = '0;
        pick[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin owner arbitration and load/run/drain sequencing
// for a shared programmable clock divider. All outputs are registered.
// Optional tenure limit: define DIV_SHARE_TIMEOUT_EN to revoke an owner after
// MAX_HOLD run cycles when another requester is waiting.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = DEF_DW,
  parameter int MIN_DIV = DEF_MIN_DIV
`ifdef DIV_SHARE_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 64
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] div_val,
  output logic [NREQ-1:0]    gnt,
  output logic               div_pl,
  output logic               div_en,
  output logic [DW-1:0]      div_din,
  output logic               busy,
  output logic               err,
  output logic [2:0]         err_id
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] owner_oh_q, owner_oh_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            pl_q, pl_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [2:0]      err_id_q, err_id_d;

  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic [DW-1:0]   cand_val;
  logic            owner_req;
  logic            revoke;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick_oh),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign cand_val  = div_val[pick_idx*DW +: DW];
  assign owner_req = |(req & owner_oh_q);

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

`ifdef DIV_SHARE_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d, hold_inc;

  // Saturating run-cycle count; revoke once it reaches the limit while others wait.
  assign hold_inc = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
  assign revoke   = (hold_inc == HW'(MAX_HOLD)) && |(req & ~owner_oh_q);
`else
  assign revoke   = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    ptr_d      = ptr_q;
    din_d      = din_q;
    gnt_d      = '0;
    pl_d       = 1'b0;
    en_d       = 1'b0;
    err_d      = 1'b0;
    err_id_d   = err_id_q;
`ifdef DIV_SHARE_TIMEOUT_EN
    hold_d     = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d    = pick_idx;
          owner_oh_d = pick_oh;
          if (cand_val >= DW'(MIN_DIV)) begin
            din_d   = cand_val;
            pl_d    = 1'b1;
            state_d = ST_LOAD;
          end else begin
            // Reject and move past this requester; it waits for the wrap.
            err_d    = 1'b1;
            err_id_d = 3'(pick_idx);
            ptr_d    = wrap_inc(pick_idx);
          end
        end
      end
      ST_LOAD: begin
        // Owner enters RUN even if it already dropped req.
        state_d = ST_RUN;
        en_d    = 1'b1;
        gnt_d   = owner_oh_q;
`ifdef DIV_SHARE_TIMEOUT_EN
        hold_d  = '0;
`endif
      end
      ST_RUN: begin
        if (!owner_req || revoke) begin
          state_d = ST_DRAIN;
        end else begin
          en_d  = 1'b1;
          gnt_d = owner_oh_q;
`ifdef DIV_SHARE_TIMEOUT_EN
          hold_d = hold_inc;
`endif
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        ptr_d   = wrap_inc(owner_q);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any tenure without a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      ptr_q      <= '0;
      din_q      <= '0;
      gnt_q      <= '0;
      pl_q       <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_id_q   <= '0;
`ifdef DIV_SHARE_TIMEOUT_EN
      hold_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      ptr_q      <= ptr_d;
      din_q      <= din_d;
      gnt_q      <= gnt_d;
      pl_q       <= pl_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
`ifdef DIV_SHARE_TIMEOUT_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign div_pl  = pl_q;
  assign div_en  = en_q;
  assign div_din = din_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign err_id  = err_id_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed and randomized tenures checked against a
// tenure-level round-robin model (pointer arithmetic plus expected timeline).
module tb_div_share_ctrl;

  localparam int NREQ    = 4;
  localparam int DW      = 16;
  localparam int MIN_DIV = 2;
  localparam int MAXH    = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] div_val = '0;
  logic [NREQ-1:0]    gnt;
  logic               div_pl;
  logic               div_en;
  logic [DW-1:0]      div_din;
  logic               busy;
  logic               err;
  logic [2:0]         err_id;

  always #5 clk = ~clk;

`ifdef DIV_SHARE_TIMEOUT_EN
  div_share_ctrl #(.NREQ(NREQ), .DW(DW), .MIN_DIV(MIN_DIV), .MAX_HOLD(MAXH)) dut (
`else
  div_share_ctrl #(.NREQ(NREQ), .DW(DW), .MIN_DIV(MIN_DIV)) dut (
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .div_val (div_val),
    .gnt     (gnt),
    .div_pl  (div_pl),
    .div_en  (div_en),
    .div_din (div_din),
    .busy    (busy),
    .err     (err),
    .err_id  (err_id)
  );

  int              n_cmp = 0;
  int              n_err = 0;
  int              ptr_m = 0;
  logic [DW-1:0]   din_m = '0;
  logic [NREQ-1:0] mask = '0;
  logic [DW-1:0]   vals [NREQ];
  int              who;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(string tag, logic [31:0] g, logic p, logic e,
                          logic [DW-1:0] d, logic b, logic er);
    chk({tag, ".gnt"},  32'(gnt),     g);
    chk({tag, ".pl"},   32'(div_pl),  32'(p));
    chk({tag, ".en"},   32'(div_en),  32'(e));
    chk({tag, ".din"},  32'(div_din), 32'(d));
    chk({tag, ".busy"}, 32'(busy),    32'(b));
    chk({tag, ".err"},  32'(err),     32'(er));
  endtask

  task automatic drive();
    req = mask;
    for (int k = 0; k < NREQ; k++) div_val[k*DW +: DW] = vals[k];
  endtask

  function automatic int rr_ref(logic [NREQ-1:0] m, int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_div();
    if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 1));
    return DW'($urandom_range(2, 65535));
  endfunction

  // One arbitration from IDLE with 'mask' driven; follows the expected timeline.
  task automatic tenure(int hold, bit early, output int owner);
    int              o;
    int              run_len;
    bit              cut;
    logic [DW-1:0]   v;
    logic [NREQ-1:0] others;
    o = rr_ref(mask, ptr_m);
    owner = o;
    if (o < 0) begin
      tick();
      chk_outs("noreq", 0, 1'b0, 1'b0, din_m, 1'b0, 1'b0);
      return;
    end
    v = vals[o];
    tick();
    if (v < DW'(MIN_DIV)) begin
      chk_outs("reject", 0, 1'b0, 1'b0, din_m, 1'b0, 1'b1);
      chk("reject.err_id", 32'(err_id), 32'(o));
      $display("txn reject owner=%0d val=%0d", o, v);
      ptr_m = (o + 1) % NREQ;
      mask[o] = 1'b0;
      drive();
      return;
    end
    din_m = v;
    chk_outs("load", 0, 1'b1, 1'b0, v, 1'b1, 1'b0);
    run_len = early ? 1 : hold;
    cut = 1'b0;
    others = mask;
    others[o] = 1'b0;
`ifdef DIV_SHARE_TIMEOUT_EN
    if (!early && hold > MAXH && others != '0) begin
      run_len = MAXH;
      cut = 1'b1;
    end
`endif
    if (early) begin
      mask[o] = 1'b0;
      drive();
    end
    for (int i = 0; i < run_len; i++) begin
      tick();
      chk_outs("run", 32'(1) << o, 1'b0, 1'b1, v, 1'b1, 1'b0);
      vals[$urandom_range(0, NREQ - 1)] = rand_div();
      drive();
    end
    if (!cut) begin
      mask[o] = 1'b0;
      drive();
    end
    tick();
    chk_outs("drain", 0, 1'b0, 1'b0, v, 1'b1, 1'b0);
    ptr_m = (o + 1) % NREQ;
    tick();
    chk_outs("gap", 0, 1'b0, 1'b0, v, 1'b0, 1'b0);
    $display("txn grant owner=%0d val=%0d run=%0d cut=%0d", o, v, run_len, cut);
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) vals[k] = DW'(5 + k);
    mask = 4'b1111;
    drive();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("reset.err_id", 32'(err_id), 0);
    rst_n = 1'b1;

    // Round robin with all requesters persistently asking: 0,1,2,3,0.
    for (int t = 0; t < 5; t++) begin
      mask = 4'b1111;
      drive();
      tenure(5, 1'b0, who);
    end

    // Single owner with divisor 3.
    mask = 4'b0010;
    vals[1] = 16'd3;
    drive();
    tenure(4, 1'b0, who);

    // Illegal divisor, then all request: pointer must have moved to 3.
    mask = 4'b0100;
    vals[2] = 16'd1;
    drive();
    tenure(1, 1'b0, who);
    for (int k = 0; k < NREQ; k++) vals[k] = DW'(10 + k);
    mask = 4'b1111;
    drive();
    tenure(2, 1'b0, who);

    // Minimum divisor boundary and owner dropping during LOAD.
    mask = 4'b0001;
    vals[0] = DW'(MIN_DIV);
    drive();
    tenure(1, 1'b1, who);

    // Reset while owner 1 runs: everything drops at once.
    mask = 4'b0010;
    vals[1] = 16'd7;
    drive();
    tick();
    chk_outs("rst_load", 0, 1'b1, 1'b0, 16'd7, 1'b1, 1'b0);
    tick();
    chk_outs("rst_run", 32'b0010, 1'b0, 1'b1, 16'd7, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_outs("rst_mid", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    $display("txn reset mid-run");
    ptr_m = 0;
    din_m = '0;
    mask = '0;
    drive();
    tick();
    rst_n = 1'b1;

    // Long holds with and without competition.
    for (int k = 0; k < NREQ; k++) vals[k] = DW'(20 + k);
    mask = 4'b0011;
    drive();
    tenure(12, 1'b0, who);
    mask = 4'b0001;
    drive();
    tenure(12, 1'b0, who);
    mask = '0;
    drive();

    // Randomized requester sets, divisors and hold lengths.
    for (int n = 0; n < 60; n++) begin
      if (mask == '0) begin
        tick();
        chk_outs("idle", 0, 1'b0, 1'b0, din_m, 1'b0, 1'b0);
        mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int k = 0; k < NREQ; k++) vals[k] = rand_div();
        drive();
      end
      tenure(int'($urandom_range(1, 12)), ($urandom_range(0, 5) == 0), who);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
